// File: rtl/wb_write_buffer.sv
// Writeback buffer: FIFO of register-write requests drained one per cycle into the regfile write port.
// Define WB_FORWARD_EN to build read-port forwarding of pending writes.
module wb_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [AW-1:0]              InReg,
  input  logic [WIDTH-1:0]           InData,
  input  logic                       Stall,
  output logic                       RegWrite,
  output logic [AW-1:0]              WriteRegister,
  output logic [WIDTH-1:0]           WriteData,
  output logic [$clog2(DEPTH):0]     Count,
  input  logic [AW-1:0]              ReadRegister1,
  input  logic [AW-1:0]              ReadRegister2,
  output logic                       Fwd1Hit,
  output logic [WIDTH-1:0]           Fwd1Data,
  output logic                       Fwd2Hit,
  output logic [WIDTH-1:0]           Fwd2Data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    regQ  [DEPTH];
  logic [WIDTH-1:0] dataQ [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    countQ;
  logic             notEmpty;
  logic             doPush;
  logic             doPop;

  assign notEmpty = (countQ != '0);
  assign InReady  = (countQ < CW'(DEPTH));
  // Writes to r0 complete the handshake but are never stored.
  assign doPush   = InValid & InReady & (InReg != '0);
  assign doPop    = RegWrite;
  assign Count    = countQ;

  assign RegWrite      = notEmpty & ~Stall;
  assign WriteRegister = notEmpty ? regQ[head]  : '0;
  assign WriteData     = notEmpty ? dataQ[head] : '0;

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      head   <= '0;
      tail   <= '0;
      countQ <= '0;
    end else begin
      if (doPop)  head <= head + PW'(1);
      if (doPush) tail <= tail + PW'(1);
      countQ <= countQ + CW'(doPush) - CW'(doPop);
    end
  end

  // Entry storage; contents are only observed while counted as valid.
  always_ff @(posedge Clk) begin
    if (doPush) begin
      regQ[tail]  <= InReg;
      dataQ[tail] <= InData;
    end
  end

`ifdef WB_FORWARD_EN
  logic [PW-1:0] idx;

  // Scan oldest to newest so the newest match wins.
  always_comb begin
    Fwd1Hit  = 1'b0;
    Fwd1Data = '0;
    Fwd2Hit  = 1'b0;
    Fwd2Data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < countQ) begin
        if ((ReadRegister1 != '0) && (regQ[idx] == ReadRegister1)) begin
          Fwd1Hit  = 1'b1;
          Fwd1Data = dataQ[idx];
        end
        if ((ReadRegister2 != '0) && (regQ[idx] == ReadRegister2)) begin
          Fwd2Hit  = 1'b1;
          Fwd2Data = dataQ[idx];
        end
      end
    end
  end
`else
  logic unusedReadAddr;
  assign unusedReadAddr = ^{ReadRegister1, ReadRegister2};
  assign Fwd1Hit  = 1'b0;
  assign Fwd1Data = '0;
  assign Fwd2Hit  = 1'b0;
  assign Fwd2Data = '0;
`endif

endmodule
